// File: rtl/handshake_pkg.sv
// Shared definitions for the two-phase handshake buffer: field positions and widths.
package handshake_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    typedef logic [$clog2(DEF_DEPTH + 1) - 1:0] level_t;

    function automatic int req_bit(input int width);
        return width - 1;
    endfunction

    function automatic int payload_w(input int width);
        return width - 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Two-wire handshake link: port1 carries {req_tgl, payload}, port2 carries the ack toggle.
interface handshake #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] port1;
    logic [WIDTH-1:0] port2;

    modport dir1 (output port1, input port2);
    modport dir2 (input port1, output port2);
endinterface

// File: rtl/handshake_fifo_mem.sv
// DEPTH x PW storage with wrap-around pointers and an occupancy counter; no protocol logic.
module handshake_fifo_mem
    import handshake_pkg::*;
#(
    parameter int PW    = 31,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [PW-1:0]                  wdata,
    output logic [PW-1:0]                  rdata,
    output logic                           full,
    output logic                           empty,
    output logic [level_w(DEPTH)-1:0]      level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr];

    // Storage is not reset: an empty level makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_buffer.sv
// Elastic two-phase toggle buffer: captures upstream words into a FIFO and re-issues them downstream.
module handshake_buffer
    import handshake_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    handshake.dir2                         inf_in,
    handshake.dir1                         inf_out,
    output logic [level_w(DEPTH)-1:0]      level,
    output logic                           err
);
    localparam int RB = req_bit(WIDTH);
    localparam int PW = payload_w(WIDTH);

    logic          in_ack;
    logic          out_req;
    logic [PW-1:0] out_payload;
    logic          ack_q;
    logic          in_req;
    logic          out_ack;
    logic          push;
    logic          launch;
    logic          full;
    logic          empty;
    logic [PW-1:0] fifo_rdata;
    logic          unused_ack_hi;

    assign in_req        = inf_in.port1[RB];
    assign out_ack       = inf_out.port2[0];
    assign unused_ack_hi = ^inf_out.port2[WIDTH-1:1];

    // Decisions use the pre-edge level, so a slot freed by launch is not reusable this cycle.
    assign push   = (in_req != in_ack) && !full;
    assign launch = (out_req == out_ack) && !empty;

    handshake_fifo_mem #(
        .PW    (PW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (launch),
        .wdata (inf_in.port1[PW-1:0]),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ack      <= 1'b0;
            out_req     <= 1'b0;
            out_payload <= '0;
        end else begin
            if (push) begin
                in_ack <= ~in_ack;
            end
            if (launch) begin
                out_payload <= fifo_rdata;
                out_req     <= ~out_req;
            end
        end
    end

    // An ack edge is legal only while our request is outstanding relative to the last ack seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            ack_q <= out_ack;
            if ((out_ack != ack_q) && (out_req == ack_q)) begin
                err <= 1'b1;
            end
        end
    end

    assign inf_in.port2  = {{(WIDTH-1){1'b0}}, in_ack};
    assign inf_out.port1 = {out_req, out_payload};

endmodule

// File: tb/tb_handshake_buffer.sv
// Directed, table-driven bench for handshake_buffer with hand-written multi-cycle sequences.
module tb_handshake_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        up_req = 1'b0;
    logic [30:0] up_data = '0;
    logic        dn_ack = 1'b0;
    logic [30:0] dn_hi = '0;
    logic [2:0]  level;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    handshake #(.WIDTH(WIDTH)) inf_in_if ();
    handshake #(.WIDTH(WIDTH)) inf_out_if ();

    assign inf_in_if.port1  = {up_req, up_data};
    assign inf_out_if.port2 = {dn_hi, dn_ack};

    handshake_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .inf_in  (inf_in_if),
        .inf_out (inf_out_if),
        .level   (level),
        .err     (err)
    );

    always #5 clk = ~clk;

    wire        in_ack      = inf_in_if.port2[0];
    wire [30:0] in_ack_hi   = inf_in_if.port2[31:1];
    wire        out_req     = inf_out_if.port1[31];
    wire [30:0] out_payload = inf_out_if.port1[30:0];

    typedef struct packed {
        logic        req;
        logic [30:0] data;
        logic        ack;
        logic        e_in_ack;
        logic        e_out_req;
        logic [30:0] e_payload;
        logic [2:0]  e_level;
        logic        e_err;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        up_req  = 1'b0;
        up_data = '0;
        dn_ack  = 1'b0;
        dn_hi   = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    localparam logic [30:0] WA = 31'h12345678;
    localparam logic [30:0] WB = 31'h0ABCDEF0;
    localparam logic [30:0] WC = 31'h7FFFFFFF;

    initial begin
        logic [30:0] w [6];
        logic [30:0] q [$];
        logic [30:0] exp_w;
        int sent;
        int got;

        // vector: req data ack | in_ack out_req payload level err
        vecs[0] = '{1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 31'h0, 3'd0, 1'b0};
        vecs[1] = '{1'b1, WA,    1'b0, 1'b1, 1'b0, 31'h0, 3'd1, 1'b0};
        vecs[2] = '{1'b1, WA,    1'b0, 1'b1, 1'b1, WA,    3'd0, 1'b0};
        vecs[3] = '{1'b0, WB,    1'b0, 1'b0, 1'b1, WA,    3'd1, 1'b0};
        vecs[4] = '{1'b1, WC,    1'b0, 1'b1, 1'b1, WA,    3'd2, 1'b0};
        vecs[5] = '{1'b1, WC,    1'b1, 1'b1, 1'b0, WB,    3'd1, 1'b0};
        vecs[6] = '{1'b1, WC,    1'b1, 1'b1, 1'b0, WB,    3'd1, 1'b0};
        vecs[7] = '{1'b1, WC,    1'b0, 1'b1, 1'b1, WC,    3'd0, 1'b0};
        vecs[8] = '{1'b1, WC,    1'b0, 1'b1, 1'b1, WC,    3'd0, 1'b0};
        vecs[9] = '{1'b1, WC,    1'b1, 1'b1, 1'b1, WC,    3'd0, 1'b0};

        // Reset with random port activity, then release with quiet inputs.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_req  = 1'($urandom);
            up_data = 31'($urandom);
            dn_ack  = 1'($urandom);
            dn_hi   = 31'($urandom);
            tick();
            check("rst_in_port2", {32'd0, in_ack_hi, in_ack}, 64'd0);
            check("rst_out_port1", {32'd0, out_req, out_payload}, 64'd0);
            check("rst_level_err", {60'd0, level, err}, 64'd0);
        end
        up_req = 1'b0; up_data = '0; dn_ack = 1'b0; dn_hi = '0;
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_hold", {27'd0, in_ack, out_req, out_payload, level, err}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            up_req  = vecs[i].req;
            up_data = vecs[i].data;
            dn_ack  = vecs[i].ack;
            tick();
            check($sformatf("vec%0d", i),
                  {27'd0, in_ack, out_req, out_payload, level, err},
                  {27'd0, vecs[i].e_in_ack, vecs[i].e_out_req, vecs[i].e_payload,
                   vecs[i].e_level, vecs[i].e_err});
        end

        // Fill: no downstream acks, sixth word must be held off.
        do_reset();
        for (int k = 0; k < 6; k++) w[k] = 31'($urandom);
        for (int k = 0; k < 5; k++) begin
            up_req  = ~up_req;
            up_data = w[k];
            tick();
            check($sformatf("fill_ack%0d", k), {63'd0, in_ack}, {63'd0, up_req});
        end
        check("fill_level4", {61'd0, level}, 64'd4);
        check("fill_out_w0", {32'd0, out_req, out_payload}, {32'd0, 1'b1, w[0]});
        up_req  = ~up_req;
        up_data = w[5];
        tick(); tick(); tick();
        check("fill_withheld", {63'd0, in_ack}, {63'd0, ~up_req});
        check("fill_level_hold", {61'd0, level}, 64'd4);
        dn_ack = 1'b1;
        tick();
        check("fill_launch_w1", {32'd0, out_payload}, {33'd0, w[1]});
        check("fill_level3", {61'd0, level}, 64'd3);
        check("fill_still_held", {63'd0, in_ack}, {63'd0, ~up_req});
        tick();
        check("fill_accept_w5", {63'd0, in_ack}, {63'd0, up_req});
        check("fill_level_back4", {61'd0, level}, 64'd4);

        // Simultaneous push and launch at level 2.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            up_req  = ~up_req;
            up_data = w[k];
            tick();
        end
        check("conc_pre_level2", {61'd0, level}, 64'd2);
        up_req  = ~up_req;
        up_data = w[3];
        dn_ack  = 1'b1;
        tick();
        check("conc_level2", {61'd0, level}, 64'd2);
        check("conc_out_w1", {32'd0, out_payload}, {33'd0, w[1]});
        check("conc_push_ack", {63'd0, in_ack}, {63'd0, up_req});

        // 100 random words with random stalls on both sides, strict FIFO order.
        do_reset();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            if (in_ack == up_req && sent < 100 && ($urandom % 4) != 0) begin
                up_req  = ~up_req;
                up_data = 31'($urandom);
                q.push_back(up_data);
                sent++;
            end
            if (out_req != dn_ack && ($urandom % 2) == 0) begin
                exp_w = q.pop_front();
                check($sformatf("order%0d", got), {33'd0, out_payload}, {33'd0, exp_w});
                dn_ack = ~dn_ack;
                got++;
            end
            tick();
        end
        check("stream_count", 64'(got), 64'd100);
        tick();
        check("stream_drained", {60'd0, level, err}, 64'd0);

        // Spurious ack while idle sets err, which survives further traffic.
        dn_ack = ~dn_ack;
        tick();
        check("err_set", {63'd0, err}, 64'd1);
        dn_ack = ~dn_ack;
        tick();
        up_req  = ~up_req;
        up_data = WB;
        tick();
        tick();
        check("err_traffic_out", {32'd0, out_payload}, {33'd0, WB});
        dn_ack = out_req;
        tick();
        tick();
        check("err_sticky", {63'd0, err}, 64'd1);

        // Asynchronous reset between edges with words in flight.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            up_req  = ~up_req;
            up_data = w[k];
            tick();
        end
        check("mid_pre_level3", {61'd0, level}, 64'd3);
        #2;
        rst = 1'b0;
        #1;
        check("mid_async_clear", {61'd0, level, out_req, in_ack}, 64'd0);
        up_req  = 1'b0;
        dn_ack  = 1'b0;
        tick();
        @(negedge clk);
        rst     = 1'b1;
        up_req  = 1'b1;
        up_data = WA;
        tick();
        check("mid_single_ack", {61'd0, level, in_ack}, {61'd0, 3'd1, 1'b1});
        tick();
        check("mid_single_out", {32'd0, out_req, out_payload}, {32'd0, 1'b1, WA});
        check("mid_single_level", {61'd0, level}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
